// File: rtl/vx_rsp_return_router_if.sv
// rtl/vx_rsp_return_router_if.sv - request-tag and response handshake bundle for the return router
interface vx_rsp_return_router_if #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_PENDING  = 8,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int CNT_WIDTH    = $clog2(MAX_PENDING + 1)
);
  logic                           req_fire_in;
  logic [LOG_NUM_REQS-1:0]        req_index_in;
  logic                           req_ready_out;
  logic                           rsp_valid_in;
  logic [DATA_WIDTH-1:0]          rsp_data_in;
  logic                           rsp_ready_out;
  logic [NUM_REQS-1:0]            rsp_valid_out;
  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_out;
  logic [NUM_REQS-1:0]            rsp_ready_in;
  logic [CNT_WIDTH-1:0]           pending_count;
  logic                           empty_out;
  logic                           error_out;

  modport slave (
    input  req_fire_in, req_index_in, rsp_valid_in, rsp_data_in, rsp_ready_in,
    output req_ready_out, rsp_ready_out, rsp_valid_out, rsp_data_out,
    output pending_count, empty_out, error_out
  );

  modport master (
    output req_fire_in, req_index_in, rsp_valid_in, rsp_data_in, rsp_ready_in,
    input  req_ready_out, rsp_ready_out, rsp_valid_out, rsp_data_out,
    input  pending_count, empty_out, error_out
  );
endinterface

// File: rtl/vx_rsp_return_router.sv
// rtl/vx_rsp_return_router.sv - records grant indices in an in-order tag FIFO and steers
// each shared response back to the requester that issued it.
module vx_rsp_return_router #(
  parameter int NUM_REQS    = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PENDING = 8
) (
  input logic                 clk,
  input logic                 reset,
  vx_rsp_return_router_if.slave bus
);
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNT_WIDTH    = $clog2(MAX_PENDING + 1);
  localparam int PTR_W        = $clog2(MAX_PENDING);

  logic [LOG_NUM_REQS-1:0] fifo_q [MAX_PENDING];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic                    error_q, error_d;

  logic                    full, empty, idx_ok, push, pop, head_ready;
  logic [LOG_NUM_REQS-1:0] head;
  logic [NUM_REQS-1:0]     valid_vec;

  always_comb begin
    full       = (count_q == CNT_WIDTH'(MAX_PENDING));
    empty      = (count_q == '0);
    head       = fifo_q[rptr_q];
    idx_ok     = (int'(bus.req_index_in) < NUM_REQS);
    push       = bus.req_fire_in && !full && idx_ok;
    valid_vec  = '0;
    head_ready = 1'b0;
    // Head is only meaningful while entries are pending; gate every lane with !empty.
    for (int i = 0; i < NUM_REQS; i++) begin
      if (int'(head) == i) begin
        valid_vec[i] = bus.rsp_valid_in && !empty;
        head_ready   = bus.rsp_ready_in[i];
      end
    end
    pop     = bus.rsp_valid_in && !empty && head_ready;
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    error_d = error_q
            | (bus.req_fire_in && (full || !idx_ok))
            | (bus.rsp_valid_in && empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= bus.req_index_in;
    end
  end

  assign bus.req_ready_out = !full;
  assign bus.rsp_ready_out = !empty && head_ready;
  assign bus.rsp_valid_out = valid_vec;
  assign bus.rsp_data_out  = {NUM_REQS{bus.rsp_data_in}};
  assign bus.pending_count = count_q;
  assign bus.empty_out     = empty;
  assign bus.error_out     = error_q;
endmodule

// File: tb/tb_vx_rsp_return_router.sv
// tb/tb_vx_rsp_return_router.sv - directed and random checks of the return router against a queue model
module tb_vx_rsp_return_router;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MP = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_rsp_return_router_if #(.NUM_REQS(N), .DATA_WIDTH(DW), .MAX_PENDING(MP)) bus ();
  vx_rsp_return_router #(.NUM_REQS(N), .DATA_WIDTH(DW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vx_rsp_return_router_if #(.NUM_REQS(3), .DATA_WIDTH(DW), .MAX_PENDING(MP)) bus3 ();
  vx_rsp_return_router #(.NUM_REQS(3), .DATA_WIDTH(DW), .MAX_PENDING(MP)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  int total = 0;
  int bad   = 0;
  int q[$];
  bit merr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus starting at a negedge; the model is a plain queue of tags.
  task automatic cycle(input bit fire, input int idx, input bit rv, input logic [31:0] rd,
                       input logic [3:0] rr);
    logic [3:0] ev;
    bit er, emp, full, push, pop;
    int head;
    bus.req_fire_in  = fire;
    bus.req_index_in = idx[1:0];
    bus.rsp_valid_in = rv;
    bus.rsp_data_in  = rd;
    bus.rsp_ready_in = rr;
    #1;
    emp  = (q.size() == 0);
    full = (q.size() == MP);
    head = emp ? 0 : q[0];
    ev   = (rv && !emp) ? 4'(1 << head) : 4'b0;
    er   = !emp && rr[head];
    chk("rsp_valid_out", 64'(bus.rsp_valid_out), 64'(ev));
    chk("rsp_ready_out", 64'(bus.rsp_ready_out), 64'(er));
    chk("req_ready_out", 64'(bus.req_ready_out), 64'(!full));
    if (ev != 4'b0) chk("lane_data", 64'(bus.rsp_data_out[head*DW +: DW]), 64'(rd));
    push = fire && !full && (idx < N);
    pop  = rv && er;
    if (fire && (full || idx >= N)) merr = 1'b1;
    if (rv && emp) merr = 1'b1;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(idx);
    @(negedge clk);
    chk("pending_count", 64'(bus.pending_count), 64'(q.size()));
    chk("empty_out", 64'(bus.empty_out), 64'(q.size() == 0));
    chk("error_out", 64'(bus.error_out), 64'(merr));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    merr = 1'b0;
  endtask

  initial begin
    bus.req_fire_in = 0; bus.req_index_in = 0; bus.rsp_valid_in = 0;
    bus.rsp_data_in = 0; bus.rsp_ready_in = 0;
    bus3.req_fire_in = 0; bus3.req_index_in = 0; bus3.rsp_valid_in = 0;
    bus3.rsp_data_in = 0; bus3.rsp_ready_in = 0;
    merr = 1'b0;
    do_reset();

    chk("rst_count", 64'(bus.pending_count), 64'd0);
    chk("rst_empty", 64'(bus.empty_out), 64'd1);
    chk("rst_ready", 64'(bus.req_ready_out), 64'd1);
    chk("rst_error", 64'(bus.error_out), 64'd0);

    // In-order routing
    cycle(1, 2, 0, 0, 4'h0);
    cycle(1, 0, 0, 0, 4'h0);
    cycle(1, 3, 0, 0, 4'h0);
    cycle(0, 0, 1, 32'hA, 4'hF);
    cycle(0, 0, 1, 32'hB, 4'hF);
    cycle(0, 0, 1, 32'hC, 4'hF);

    // Full, overflow error, pointer wrap, drain in order
    for (int i = 0; i < MP; i++) cycle(1, int'($urandom_range(0, N-1)), 0, 0, 4'h0);
    cycle(1, 1, 0, 0, 4'h0);
    cycle(1, 2, 1, $urandom, 4'hF);
    cycle(1, 3, 1, $urandom, 4'hF);
    cycle(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < MP; i++) cycle(0, 0, 1, $urandom, 4'hF);

    // Backpressure on lane 1
    do_reset();
    cycle(1, 1, 0, 0, 4'h0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h55, 4'b1101);
    cycle(0, 0, 1, 32'h66, 4'hF);

    // Response while empty, then push and respond in the same cycle
    do_reset();
    cycle(0, 0, 1, 32'h77, 4'hF);
    cycle(0, 0, 0, 0, 4'h0);
    cycle(1, 2, 1, 32'h88, 4'hF);
    cycle(0, 0, 1, 32'h88, 4'hF);

    // Random traffic
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 1), int'($urandom_range(0, N-1)), $urandom_range(0, 1),
            $urandom, 4'($urandom));

    // Asynchronous reset mid-cycle with three tags pending
    do_reset();
    cycle(1, 1, 0, 0, 4'h0);
    cycle(1, 2, 0, 0, 4'h0);
    cycle(1, 3, 0, 0, 4'h0);
    bus.rsp_valid_in = 1; bus.rsp_ready_in = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(bus.pending_count), 64'd0);
    chk("arst_empty", 64'(bus.empty_out), 64'd1);
    chk("arst_ready", 64'(bus.req_ready_out), 64'd1);
    chk("arst_valid", 64'(bus.rsp_valid_out), 64'd0);
    chk("arst_rspready", 64'(bus.rsp_ready_out), 64'd0);
    chk("arst_error", 64'(bus.error_out), 64'd0);
    bus.rsp_valid_in = 0; bus.rsp_ready_in = 0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    merr = 1'b0;

    // Out-of-range index with three requesters
    bus3.req_fire_in = 1; bus3.req_index_in = 2'd3;
    @(negedge clk);
    chk("bad_idx_count", 64'(bus3.pending_count), 64'd0);
    chk("bad_idx_error", 64'(bus3.error_out), 64'd1);
    bus3.req_index_in = 2'd2;
    @(negedge clk);
    bus3.req_fire_in = 0;
    chk("good_idx_count", 64'(bus3.pending_count), 64'd1);
    bus3.rsp_valid_in = 1; bus3.rsp_ready_in = 3'b100;
    #1;
    chk("lane2_valid", 64'(bus3.rsp_valid_out), 64'b100);
    bus3.rsp_valid_in = 0;
    @(negedge clk);
    chk("sticky_error", 64'(bus3.error_out), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
